imem_fetch_arbiter: RTL and testbench



---
 rtl/imem_pkg.sv | 24 ++
 rtl/imem_arb_prio.sv | 36 +++
 rtl/imem_fetch_arbiter.sv | 162 ++++++++++++++++
 tb/tb_imem_fetch_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch arbiter.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    OWN_FETCH,
    OWN_DEBUG
  } owner_e;

  localparam int WORD_BYTES = 4;
  localparam int STARVE_W   = 4;  // holds STARVE_LIMIT up to 15
  localparam int LAT_W      = 3;  // wait counter for MEM_LATENCY up to 7

  // Bit positions inside the one-hot grant vector
  localparam int GNT_F = 0;
  localparam int GNT_D = 1;

endpackage

// File: rtl/imem_arb_prio.sv
// Fixed-priority arbiter (fetch first) with a starvation counter that forces
// a debug win after STARVE_LIMIT consecutive contended fetch wins.
module imem_arb_prio
  import imem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                f_req_i,
  input  logic                d_req_i,
  input  logic [STARVE_W-1:0] starve_cnt_i,
  output logic [1:0]          gnt_oh_o,
  output logic [STARVE_W-1:0] starve_cnt_o
);

  always_comb begin
    gnt_oh_o     = 2'b00;
    starve_cnt_o = starve_cnt_i;
    if (f_req_i && d_req_i) begin
      if (starve_cnt_i == STARVE_W'(STARVE_LIMIT)) begin
        gnt_oh_o[GNT_D] = 1'b1;
        starve_cnt_o    = '0;
      end else begin
        gnt_oh_o[GNT_F] = 1'b1;
        if (starve_cnt_i != {STARVE_W{1'b1}}) begin
          starve_cnt_o = starve_cnt_i + 1'b1;
        end
      end
    end else if (f_req_i) begin
      gnt_oh_o[GNT_F] = 1'b1;
    end else if (d_req_i) begin
      gnt_oh_o[GNT_D] = 1'b1;
      starve_cnt_o    = '0;
    end
  end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Shares one instruction-memory read port between fetch and debug requesters.
// Define IMEM_BOUNDS_CHECK_EN to reject word indices >= DEPTH without a memory access.
module imem_fetch_arbiter
  import imem_pkg::*;
#(
  parameter int DEPTH        = 1000,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                f_req,
  input  logic [31:0]         f_addr,
  output logic                f_gnt,
  output logic                f_rvalid,
  output logic [31:0]         f_rdata,
  output logic                f_err,
  input  logic                d_req,
  input  logic [31:0]         d_addr,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [31:0]         d_rdata,
  output logic                d_err,
  output logic                mem_en,
  output logic [31:0]         mem_addr,
  input  logic [31:0]         mem_rdata,
  output logic                busy,
  output state_e              dbg_state,
  output logic [STARVE_W-1:0] dbg_starve_cnt
);

`ifdef IMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [31:0]         idx_q, idx_d;
  logic [LAT_W-1:0]    wcnt_q, wcnt_d;
  logic [STARVE_W-1:0] starve_q, starve_d, arb_starve;
  logic [31:0]         f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
  logic                f_err_q, f_err_d, d_err_q, d_err_d;

  logic [1:0]          arb_gnt;
  logic                can_grant, grant, sel_dbg;
  logic [31:0]         sel_addr, sel_idx;
  logic                sel_err, last_wait;

  imem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .f_req_i      (f_req),
    .d_req_i      (d_req),
    .starve_cnt_i (starve_q),
    .gnt_oh_o     (arb_gnt),
    .starve_cnt_o (arb_starve)
  );

  // Grants overlap RESP so back-to-back accesses cost MEM_LATENCY+2 cycles.
  assign can_grant = rst_n && (state_q == IDLE || state_q == RESP);
  assign grant     = can_grant && (arb_gnt != 2'b00);
  assign sel_dbg   = arb_gnt[GNT_D];
  assign sel_addr  = sel_dbg ? d_addr : f_addr;
  assign sel_idx   = sel_addr >> $clog2(WORD_BYTES);
  assign sel_err   = ((sel_addr & 32'(WORD_BYTES - 1)) != 32'd0) ||
                     (BOUNDS_EN && (sel_idx >= 32'(DEPTH)));
  assign last_wait = (state_q == WAIT) && (wcnt_q == LAT_W'(MEM_LATENCY - 1));

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    starve_d  = starve_q;
    f_rdata_d = f_rdata_q;
    f_err_d   = f_err_q;
    d_rdata_d = d_rdata_q;
    d_err_d   = d_err_q;

    if (grant) begin
      owner_d  = sel_dbg ? OWN_DEBUG : OWN_FETCH;
      idx_d    = sel_idx;
      starve_d = arb_starve;
    end

    case (state_q)
      IDLE:  if (grant) state_d = sel_err ? RESP : ISSUE;
      ISSUE: begin
        state_d = WAIT;
        wcnt_d  = '0;
      end
      WAIT: begin
        if (last_wait) state_d = RESP;
        else           wcnt_d  = wcnt_q + 1'b1;
      end
      RESP: begin
        if (grant) state_d = sel_err ? RESP : ISSUE;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Response registers hold until the owner's next response.
    if (last_wait) begin
      if (owner_q == OWN_DEBUG) begin
        d_rdata_d = mem_rdata;
        d_err_d   = 1'b0;
      end else begin
        f_rdata_d = mem_rdata;
        f_err_d   = 1'b0;
      end
    end
    if (grant && sel_err) begin
      if (sel_dbg) begin
        d_rdata_d = '0;
        d_err_d   = 1'b1;
      end else begin
        f_rdata_d = '0;
        f_err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_FETCH;
      idx_q     <= '0;
      wcnt_q    <= '0;
      starve_q  <= '0;
      f_rdata_q <= '0;
      f_err_q   <= 1'b0;
      d_rdata_q <= '0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      idx_q     <= idx_d;
      wcnt_q    <= wcnt_d;
      starve_q  <= starve_d;
      f_rdata_q <= f_rdata_d;
      f_err_q   <= f_err_d;
      d_rdata_q <= d_rdata_d;
      d_err_q   <= d_err_d;
    end
  end

  assign f_gnt          = grant && !sel_dbg;
  assign d_gnt          = grant && sel_dbg;
  assign f_rvalid       = (state_q == RESP) && (owner_q == OWN_FETCH);
  assign d_rvalid       = (state_q == RESP) && (owner_q == OWN_DEBUG);
  assign f_rdata        = f_rdata_q;
  assign f_err          = f_err_q;
  assign d_rdata        = d_rdata_q;
  assign d_err          = d_err_q;
  assign mem_en         = (state_q == ISSUE);
  assign mem_addr       = (state_q == ISSUE) ? idx_q : 32'd0;
  assign busy           = (state_q == ISSUE) || (state_q == WAIT);
  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_q;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter: latency-1 instance for the main
// sequence, latency-3 instance for back-to-back throughput.
module tb_imem_fetch_arbiter;
  import imem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        f_req = 1'b0, d_req = 1'b0;
  logic [31:0] f_addr = '0, d_addr = '0;
  logic        f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err, mem_en, busy;
  logic [31:0] f_rdata, d_rdata, mem_addr, mem_rdata;
  state_e      dbg_state;
  logic [3:0]  dbg_starve_cnt;

  logic        f_req3 = 1'b0, d_req3 = 1'b0;
  logic [31:0] f_addr3 = '0, d_addr3 = '0;
  logic        f_gnt3, f_rvalid3, f_err3, d_gnt3, d_rvalid3, d_err3, mem_en3, busy3;
  logic [31:0] f_rdata3, d_rdata3, mem_addr3, mem_rdata3;
  state_e      dbg_state3;
  logic [3:0]  dbg_starve_cnt3;

  int n_vec = 0;
  int n_err = 0;
  int mem_en_cnt = 0;

  // clock / reset
  always #5 clk = ~clk;

  imem_fetch_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  imem_fetch_arbiter #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req3), .f_addr(f_addr3), .f_gnt(f_gnt3), .f_rvalid(f_rvalid3),
    .f_rdata(f_rdata3), .f_err(f_err3),
    .d_req(d_req3), .d_addr(d_addr3), .d_gnt(d_gnt3), .d_rvalid(d_rvalid3),
    .d_rdata(d_rdata3), .d_err(d_err3),
    .mem_en(mem_en3), .mem_addr(mem_addr3), .mem_rdata(mem_rdata3), .busy(busy3),
    .dbg_state(dbg_state3), .dbg_starve_cnt(dbg_starve_cnt3)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] idx);
    if (idx == 32'd2) return 32'hDEADBEEF;
    return {16'hC0DE, idx[15:0]};
  endfunction

  // memory models: data is only meaningful exactly MEM_LATENCY cycles after mem_en
  logic        m1_v = 1'b0;
  logic [31:0] m1_d = '0;
  always @(posedge clk) begin
    m1_v <= mem_en;
    m1_d <= mem_word(mem_addr);
  end
  assign mem_rdata = m1_v ? m1_d : 32'hBADBAD00;

  logic        m3_v [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] m3_d [3] = '{32'd0, 32'd0, 32'd0};
  always @(posedge clk) begin
    m3_v[0] <= mem_en3;
    m3_d[0] <= mem_word(mem_addr3);
    m3_v[1] <= m3_v[0];
    m3_d[1] <= m3_d[0];
    m3_v[2] <= m3_v[1];
    m3_d[2] <= m3_d[1];
  end
  assign mem_rdata3 = m3_v[2] ? m3_d[2] : 32'hBADBAD00;

  always @(negedge clk) if (mem_en) mem_en_cnt++;

  // driver / check helpers
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout vectors=%0d miscompares=%0d", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int mem_en_snap;
    int waited;
    logic [31:0] flags;
    logic        exp_dbg [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0]  exp_cnt [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};

    // reset state
    tick();
    tick();
    flags = {24'd0, f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err, mem_en, busy};
    chk32("rst_flags", flags, 32'd0);
    chk32("rst_f_rdata", f_rdata, 32'd0);
    chk32("rst_d_rdata", d_rdata, 32'd0);
    chk32("rst_mem_addr", mem_addr, 32'd0);
    chk32("rst_state", 32'(dbg_state), 32'(IDLE));
    chk32("rst_starve", 32'(dbg_starve_cnt), 32'd0);
    rst_n = 1'b1;

    // fetch 0x8 -> word 2
    f_req = 1'b1; f_addr = 32'h8; #1;
    chk1("t1_f_gnt", f_gnt, 1'b1);
    chk1("t1_d_gnt", d_gnt, 1'b0);
    chk1("t1_mem_en_c0", mem_en, 1'b0);
    tick(); f_req = 1'b0; #1;
    chk1("t1_mem_en", mem_en, 1'b1);
    chk32("t1_mem_addr", mem_addr, 32'd2);
    chk1("t1_busy_issue", busy, 1'b1);
    chk1("t1_f_gnt_issue", f_gnt, 1'b0);
    tick();
    chk1("t1_busy_wait", busy, 1'b1);
    chk1("t1_mem_en_wait", mem_en, 1'b0);
    chk1("t1_rvalid_early", f_rvalid, 1'b0);
    tick();
    chk1("t1_f_rvalid", f_rvalid, 1'b1);
    chk32("t1_f_rdata", f_rdata, 32'hDEADBEEF);
    chk1("t1_f_err", f_err, 1'b0);
    chk1("t1_d_rvalid", d_rvalid, 1'b0);
    chk1("t1_busy_resp", busy, 1'b0);
    tick();
    chk1("t1_f_rvalid_pulse", f_rvalid, 1'b0);
    chk32("t1_f_rdata_hold", f_rdata, 32'hDEADBEEF);

    // misaligned fetch
    mem_en_snap = mem_en_cnt;
    f_req = 1'b1; f_addr = 32'h6; #1;
    chk1("t2_f_gnt", f_gnt, 1'b1);
    tick(); f_req = 1'b0; #1;
    chk1("t2_f_rvalid", f_rvalid, 1'b1);
    chk1("t2_f_err", f_err, 1'b1);
    chk32("t2_f_rdata", f_rdata, 32'd0);
    chk1("t2_mem_en", mem_en, 1'b0);
    chk1("t2_busy", busy, 1'b0);
    tick();
    chk1("t2_f_rvalid_pulse", f_rvalid, 1'b0);
    chk1("t2_f_err_hold", f_err, 1'b1);
    chk32("t2_mem_en_count", 32'(mem_en_cnt), 32'(mem_en_snap));

    // debug read of word index 1000
    mem_en_snap = mem_en_cnt;
    d_req = 1'b1; d_addr = 32'hFA0; #1;
    chk1("t3_d_gnt", d_gnt, 1'b1);
    chk1("t3_f_gnt", f_gnt, 1'b0);
    tick(); d_req = 1'b0; #1;
`ifdef IMEM_BOUNDS_CHECK_EN
    chk1("t3_d_rvalid", d_rvalid, 1'b1);
    chk1("t3_d_err", d_err, 1'b1);
    chk32("t3_d_rdata", d_rdata, 32'd0);
    chk1("t3_mem_en", mem_en, 1'b0);
    tick();
    chk32("t3_mem_en_count", 32'(mem_en_cnt), 32'(mem_en_snap));
    tick();
`else
    chk1("t3_mem_en", mem_en, 1'b1);
    chk32("t3_mem_addr", mem_addr, 32'd1000);
    tick();
    tick();
    chk1("t3_d_rvalid", d_rvalid, 1'b1);
    chk1("t3_d_err", d_err, 1'b0);
    chk32("t3_d_rdata", d_rdata, 32'hC0DE03E8);
    chk1("t3_f_rvalid", f_rvalid, 1'b0);
    tick();
`endif

    // contention: F,F,F,F,D,F,F,F,F,D
    f_req = 1'b1; f_addr = 32'h10;
    d_req = 1'b1; d_addr = 32'h14; #1;
    for (int k = 0; k < 10; k++) begin
      waited = 0;
      while (!(f_gnt || d_gnt) && waited < 12) begin
        tick();
        waited++;
      end
      chk1($sformatf("t4_gnt_seen_%0d", k), f_gnt || d_gnt, 1'b1);
      chk1($sformatf("t4_d_gnt_%0d", k), d_gnt, exp_dbg[k]);
      chk1($sformatf("t4_f_gnt_%0d", k), f_gnt, !exp_dbg[k]);
      if (k > 0) begin
        chk32($sformatf("t4_spacing_%0d", k), 32'(waited), 32'd2);
        if (exp_dbg[k-1]) begin
          chk1($sformatf("t4_prev_d_rvalid_%0d", k), d_rvalid, 1'b1);
          chk32($sformatf("t4_prev_d_rdata_%0d", k), d_rdata, 32'hC0DE0005);
        end else begin
          chk1($sformatf("t4_prev_f_rvalid_%0d", k), f_rvalid, 1'b1);
          chk32($sformatf("t4_prev_f_rdata_%0d", k), f_rdata, 32'hC0DE0004);
        end
      end
      tick();
      if (k == 9) begin
        f_req = 1'b0;
        d_req = 1'b0;
      end
      #1;
      chk32($sformatf("t4_starve_%0d", k), 32'(dbg_starve_cnt), 32'(exp_cnt[k]));
    end
    tick();
    tick();
    chk1("t4_last_d_rvalid", d_rvalid, 1'b1);
    chk32("t4_last_d_rdata", d_rdata, 32'hC0DE0005);
    chk1("t4_last_f_rvalid", f_rvalid, 1'b0);
    tick();

    // reset pulsed during WAIT
    f_req = 1'b1; f_addr = 32'hC; #1;
    chk1("t5_f_gnt", f_gnt, 1'b1);
    tick(); f_req = 1'b0;
    tick();
    chk32("t5_state_wait", 32'(dbg_state), 32'(WAIT));
    rst_n = 1'b0; #1;
    flags = {24'd0, f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err, mem_en, busy};
    chk32("t5_rst_flags", flags, 32'd0);
    chk32("t5_rst_f_rdata", f_rdata, 32'd0);
    chk32("t5_rst_d_rdata", d_rdata, 32'd0);
    chk32("t5_rst_state", 32'(dbg_state), 32'(IDLE));
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk1($sformatf("t5_no_stray_%0d", c), f_rvalid || d_rvalid || busy, 1'b0);
    end
    f_req = 1'b1; f_addr = 32'h8; #1;
    chk1("t5_post_gnt", f_gnt, 1'b1);
    tick(); f_req = 1'b0;
    tick();
    tick();
    chk1("t5_post_rvalid", f_rvalid, 1'b1);
    chk32("t5_post_rdata", f_rdata, 32'hDEADBEEF);
    tick();

    // MEM_LATENCY=3 back-to-back fetches
    f_req3 = 1'b1; f_addr3 = 32'h0; #1;
    chk1("t6_gnt0", f_gnt3, 1'b1);
    tick(); f_addr3 = 32'h4; #1;
    chk1("t6_mem_en0", mem_en3, 1'b1);
    chk32("t6_mem_addr0", mem_addr3, 32'd0);
    chk1("t6_busy_issue0", busy3, 1'b1);
    chk1("t6_no_gnt_issue", f_gnt3, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk1($sformatf("t6_busy_wait_c%0d", c), busy3, 1'b1);
      chk1($sformatf("t6_no_rvalid_c%0d", c), f_rvalid3, 1'b0);
    end
    tick();
    chk1("t6_rvalid0", f_rvalid3, 1'b1);
    chk32("t6_rdata0", f_rdata3, 32'hC0DE0000);
    chk1("t6_gnt1", f_gnt3, 1'b1);
    chk1("t6_busy_resp0", busy3, 1'b0);
    tick(); f_req3 = 1'b0; #1;
    chk1("t6_mem_en1", mem_en3, 1'b1);
    chk32("t6_mem_addr1", mem_addr3, 32'd1);
    for (int c = 7; c <= 9; c++) begin
      tick();
      chk1($sformatf("t6_busy_wait_c%0d", c), busy3, 1'b1);
      chk1($sformatf("t6_no_rvalid_c%0d", c), f_rvalid3, 1'b0);
    end
    tick();
    chk1("t6_rvalid1", f_rvalid3, 1'b1);
    chk32("t6_rdata1", f_rdata3, 32'hC0DE0001);
    chk1("t6_err1", f_err3, 1'b0);
    tick();
    chk32("t6_idle", 32'(dbg_state3), 32'(IDLE));

    // report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
